// File: rtl/mpm_port_scheduler.sv
// rtl/mpm_port_scheduler.sv - round-robin requester-to-port scheduler for a multi-ported memory
// Grants up to PORTS non-conflicting requests per cycle and returns read data one cycle later.
module mpm_port_scheduler #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int PORTS      = 4,
  parameter int REQUESTERS = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] req_valid,
  input  logic [REQUESTERS-1:0] req_we,
  input  logic [ADDR_W-1:0]     req_addr  [REQUESTERS-1:0],
  input  logic [WIDTH-1:0]      req_wdata [REQUESTERS-1:0],
  output logic [REQUESTERS-1:0] req_ready,
  output logic [REQUESTERS-1:0] rsp_valid,
  output logic [WIDTH-1:0]      rsp_data  [REQUESTERS-1:0],
  output logic [ADDR_W-1:0]     mem_addr  [PORTS-1:0],
  output logic [PORTS-1:0]      mem_en,
  output logic [WIDTH-1:0]      mem_d     [PORTS-1:0],
  input  logic [WIDTH-1:0]      mem_q     [PORTS-1:0],
  output logic [15:0]           conflict_count
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int RW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CW = $clog2(REQUESTERS + 1);

  logic [RW-1:0]         rr_ptr;
  logic [RW-1:0]         last_idx;
  logic [RW-1:0]         idx;
  logic                  any_grant;
  logic                  conflict;
  logic [PW:0]           n_grant;
  logic [CW-1:0]         deferred;
  logic [PW-1:0]         grant_port [REQUESTERS-1:0];
  logic [REQUESTERS-1:0] rsp_pend;
  logic [PW-1:0]         rsp_port   [REQUESTERS-1:0];
  logic [16:0]           cc_sum;

  // Scan from rr_ptr; ports fill in scan order, conflicts are checked only
  // against requests already granted this cycle, and scanning stops once
  // every port is taken so the leftovers are not counted as conflicts.
  always_comb begin
    req_ready = '0;
    mem_en    = '0;
    for (int p = 0; p < PORTS; p++) begin
      mem_addr[p] = '0;
      mem_d[p]    = '0;
    end
    for (int r = 0; r < REQUESTERS; r++) grant_port[r] = '0;
    n_grant   = '0;
    deferred  = '0;
    last_idx  = rr_ptr;
    any_grant = 1'b0;
    conflict  = 1'b0;
    idx       = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = RW'((int'(rr_ptr) + i) % REQUESTERS);
      if (!rst && req_valid[idx] && (n_grant < (PW+1)'(PORTS))) begin
        conflict = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
          if (((PW+1)'(p) < n_grant) && (mem_addr[p] == req_addr[idx]) &&
              (mem_en[p] || req_we[idx]))
            conflict = 1'b1;
        end
        if (conflict) begin
          deferred = deferred + CW'(1);
        end else begin
          req_ready[idx]         = 1'b1;
          grant_port[idx]        = n_grant[PW-1:0];
          mem_addr[n_grant[PW-1:0]] = req_addr[idx];
          mem_en[n_grant[PW-1:0]]   = req_we[idx];
          mem_d[n_grant[PW-1:0]]    = req_we[idx] ? req_wdata[idx] : '0;
          n_grant   = n_grant + (PW+1)'(1);
          last_idx  = idx;
          any_grant = 1'b1;
        end
      end
    end
  end

  assign cc_sum = {1'b0, conflict_count} + 17'(deferred);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      rsp_pend       <= '0;
      conflict_count <= '0;
      for (int r = 0; r < REQUESTERS; r++) rsp_port[r] <= '0;
    end else begin
      if (any_grant) rr_ptr <= RW'((int'(last_idx) + 1) % REQUESTERS);
      rsp_pend       <= req_ready & ~req_we;
      conflict_count <= cc_sum[16] ? 16'hFFFF : cc_sum[15:0];
      for (int r = 0; r < REQUESTERS; r++) rsp_port[r] <= grant_port[r];
    end
  end

  // Masking with rst drops a response whose read was granted just before reset.
  always_comb begin
    for (int r = 0; r < REQUESTERS; r++) begin
      rsp_valid[r] = rsp_pend[r] & ~rst;
      rsp_data[r]  = rsp_valid[r] ? mem_q[rsp_port[r]] : '0;
    end
  end

endmodule

// File: tb/tb_mpm_port_scheduler.sv
// tb/tb_mpm_port_scheduler.sv - directed self-checking bench for mpm_port_scheduler
module tb_mpm_port_scheduler;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int P  = 2;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [R-1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [AW-1:0] req_addr  [R-1:0];
  logic [W-1:0]  req_wdata [R-1:0];
  logic [W-1:0]  rsp_data  [R-1:0];
  logic [AW-1:0] mem_addr  [P-1:0];
  logic [P-1:0]  mem_en;
  logic [W-1:0]  mem_d     [P-1:0];
  logic [W-1:0]  mem_q     [P-1:0];
  logic [15:0]   conflict_count;
  logic [W-1:0]  mem [D];

  int n_tests = 0;
  int n_fail  = 0;

  mpm_port_scheduler #(.WIDTH(W), .DEPTH(D), .PORTS(P), .REQUESTERS(R)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_d(mem_d), .mem_q(mem_q),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle read latency; contents reload to 8'h30+addr on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < D; a++) mem[a] <= 8'h30 + 8'(a);
    end else begin
      for (int p = 0; p < P; p++) if (mem_en[p]) mem[mem_addr[p]] <= mem_d[p];
    end
    for (int p = 0; p < P; p++) mem_q[p] <= mem[mem_addr[p]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clr;
    req_valid = '0;
    req_we    = '0;
    for (int r = 0; r < R; r++) begin
      req_addr[r]  = '0;
      req_wdata[r] = '0;
    end
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    req_addr[r]  = a;
    req_wdata[r] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    tick();
    tick();
    // requests present while in reset must not be granted
    set_req(0, 1'b1, 4'd5, 8'h55);
    set_req(1, 1'b0, 4'd6, 8'hEE);
    settle();
    check("rst_ready", req_ready, 4'h0);
    check("rst_en", mem_en, 2'b00);
    check("rst_addr0", mem_addr[0], 4'd0);
    check("rst_d0", mem_d[0], 8'h00);
    check("rst_rsp", rsp_valid, 4'h0);
    check("rst_cc", conflict_count, 16'h0);
    tick();
    clr();
    rst = 1'b0;

    // full load, distinct read addresses
    set_req(0, 1'b0, 4'd1, 8'hEE);
    set_req(1, 1'b0, 4'd2, 8'hEE);
    set_req(2, 1'b0, 4'd4, 8'hEE);
    set_req(3, 1'b0, 4'd5, 8'hEE);
    settle();
    check("fl0_ready", req_ready, 4'h3);
    check("fl0_addr0", mem_addr[0], 4'd1);
    check("fl0_addr1", mem_addr[1], 4'd2);
    check("fl0_en", mem_en, 2'b00);
    check("fl0_d0", mem_d[0], 8'h00);
    check("fl0_rsp", rsp_valid, 4'h0);
    tick(); settle();
    check("fl1_ready", req_ready, 4'hC);
    check("fl1_addr0", mem_addr[0], 4'd4);
    check("fl1_addr1", mem_addr[1], 4'd5);
    check("fl1_rsp", rsp_valid, 4'h3);
    check("fl1_data0", rsp_data[0], 8'h31);
    check("fl1_data1", rsp_data[1], 8'h32);
    tick(); settle();
    check("fl2_ready", req_ready, 4'h3);
    check("fl2_rsp", rsp_valid, 4'hC);
    check("fl2_data2", rsp_data[2], 8'h34);
    check("fl2_data3", rsp_data[3], 8'h35);
    tick(); clr(); settle();
    check("fl3_ready", req_ready, 4'h0);
    check("fl3_addr0", mem_addr[0], 4'd0);
    check("fl3_rsp", rsp_valid, 4'h3);
    check("fl3_data0", rsp_data[0], 8'h31);
    check("fl3_data2_idle", rsp_data[2], 8'h00);
    tick(); settle();
    check("fl4_rsp", rsp_valid, 4'h0);

    // write/read conflict on the same address
    do_reset();
    set_req(0, 1'b1, 4'd3, 8'hA5);
    set_req(1, 1'b0, 4'd3, 8'hEE);
    settle();
    check("wc0_ready", req_ready, 4'h1);
    check("wc0_en", mem_en, 2'b01);
    check("wc0_addr0", mem_addr[0], 4'd3);
    check("wc0_d0", mem_d[0], 8'hA5);
    check("wc0_addr1", mem_addr[1], 4'd0);
    check("wc0_cc", conflict_count, 16'd0);
    tick(); req_valid[0] = 1'b0; settle();
    check("wc1_ready", req_ready, 4'h2);
    check("wc1_addr0", mem_addr[0], 4'd3);
    check("wc1_cc", conflict_count, 16'd1);
    check("wc1_rsp", rsp_valid, 4'h0);
    tick(); clr(); settle();
    check("wc2_rsp", rsp_valid, 4'h2);
    check("wc2_data1", rsp_data[1], 8'hA5);

    // read sharing
    do_reset();
    set_req(2, 1'b0, 4'd7, 8'h00);
    set_req(3, 1'b0, 4'd7, 8'h00);
    settle();
    check("rs0_ready", req_ready, 4'hC);
    check("rs0_addr0", mem_addr[0], 4'd7);
    check("rs0_addr1", mem_addr[1], 4'd7);
    tick(); clr(); settle();
    check("rs1_rsp", rsp_valid, 4'hC);
    check("rs1_data2", rsp_data[2], 8'h37);
    check("rs1_data3", rsp_data[3], 8'h37);
    check("rs1_cc", conflict_count, 16'd0);

    // pointer wrap
    do_reset();
    set_req(3, 1'b0, 4'd9, 8'h00);
    settle();
    check("pw0_ready", req_ready, 4'h8);
    check("pw0_addr0", mem_addr[0], 4'd9);
    tick(); clr();
    set_req(0, 1'b0, 4'd10, 8'h00);
    set_req(3, 1'b0, 4'd11, 8'h00);
    settle();
    check("pw1_ready", req_ready, 4'h9);
    check("pw1_addr0", mem_addr[0], 4'd10);
    check("pw1_addr1", mem_addr[1], 4'd11);
    check("pw1_rsp", rsp_valid, 4'h8);
    check("pw1_data3", rsp_data[3], 8'h39);
    tick(); clr();

    // reset right after a granted read
    do_reset();
    set_req(0, 1'b1, 4'd6, 8'h11);
    set_req(1, 1'b0, 4'd6, 8'hEE);
    settle();
    check("rm0_ready", req_ready, 4'h1);
    tick(); req_valid[0] = 1'b0; settle();
    check("rm1_ready", req_ready, 4'h2);
    check("rm1_cc", conflict_count, 16'd1);
    tick(); rst = 1'b1; clr(); settle();
    check("rm2_rsp", rsp_valid, 4'h0);
    check("rm2_ready", req_ready, 4'h0);
    tick(); rst = 1'b0;
    set_req(0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b0, 4'd2, 8'h00);
    set_req(2, 1'b0, 4'd4, 8'h00);
    set_req(3, 1'b0, 4'd5, 8'h00);
    settle();
    check("rm3_ready", req_ready, 4'h3);
    check("rm3_cc", conflict_count, 16'd0);
    check("rm3_rsp", rsp_valid, 4'h0);
    tick(); clr();

    // saturation: four writers on one address defer three per cycle
    do_reset();
    for (int r = 0; r < R; r++) set_req(r, 1'b1, 4'd0, 8'h00);
    settle();
    check("sat0_ready", req_ready, 4'h1);
    check("sat0_cc", conflict_count, 16'd0);
    repeat (10) tick();
    settle();
    check("sat10_cc", conflict_count, 16'd30);
    check("sat10_ready", req_ready, 4'h4);
    repeat (21840) tick();
    settle();
    check("sat_cc", conflict_count, 16'hFFFF);
    tick(); settle();
    check("sat_hold_cc", conflict_count, 16'hFFFF);
    clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mpm_port_scheduler.md
MPM_PORT_SCHEDULER -- requirements
Module: mpm_port_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the memory word count; ADDR_W = $clog2(DEPTH).
REQ-003 The block SHALL have parameter PORTS, default 4, meaning the number of multi-ported memory ports, with PORTS >= 2.
REQ-004 The block SHALL have parameter REQUESTERS, default 8, meaning the number of requesters, with REQUESTERS >= PORTS.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_valid[REQUESTERS-1:0], input, 1 bit each: the requester holds a request.
REQ-008 The block SHALL have port req_we[REQUESTERS-1:0], input, 1 bit each: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr[REQUESTERS-1:0], input, ADDR_W each: the word address.
REQ-010 The block SHALL have port req_wdata[REQUESTERS-1:0], input, WIDTH each: the write data.
REQ-011 The block SHALL have port req_ready[REQUESTERS-1:0], output, 1 bit each: the request is granted this cycle (combinational).
REQ-012 The block SHALL have port rsp_valid[REQUESTERS-1:0], output, 1 bit each: read data is present on rsp_data.
REQ-013 The block SHALL have port rsp_data[REQUESTERS-1:0], output, WIDTH each: the read data.
REQ-014 The block SHALL have port mem_addr[PORTS-1:0], output, ADDR_W each: per-port address to the memory.
REQ-015 The block SHALL have port mem_en[PORTS-1:0], output, 1 bit each: per-port write enable to the memory.
REQ-016 The block SHALL have port mem_d[PORTS-1:0], output, WIDTH each: per-port write data.
REQ-017 The block SHALL have port mem_q[PORTS-1:0], input, WIDTH each: per-port read data, valid one cycle after the address is presented.
REQ-018 The block SHALL have port conflict_count, output, 16 bits: a saturating count of deferred requests.

Function
REQ-019 The block SHALL scan requesters each cycle in round-robin order, starting at the pointer rr_ptr and wrapping modulo REQUESTERS.
REQ-020 The block SHALL grant at most PORTS valid requests per cycle, assigning the k-th grant in scan order to memory port k.
REQ-021 Conflict rule: a valid request SHALL be deferred when both hold:
- its address equals that of a request already granted this cycle;
- either of the two requests is a write.
REQ-022 Same-address read/read pairs SHALL both be granted.
REQ-023 A deferred request SHALL NOT consume a port, and scanning SHALL continue past it.
REQ-024 For a granted request, req_ready SHALL be 1 in the same cycle and the assigned port SHALL be driven as follows:
- mem_addr = req_addr;
- mem_en = req_we;
- mem_d = req_wdata when req_we=1, else 0.
REQ-025 Unassigned ports SHALL drive mem_addr=0, mem_en=0, mem_d=0.
REQ-026 A read granted in cycle t SHALL produce, in cycle t+1 only, rsp_valid=1 for that requester with rsp_data = mem_q[assigned port].
REQ-027 A requester without rsp_valid SHALL see rsp_data=0.
REQ-028 A write SHALL produce no response.
REQ-029 rr_ptr SHALL update as follows:
- when at least one grant occurs: to (index of last granted requester + 1) mod REQUESTERS;
- when no grant occurs: unchanged.
REQ-030 conflict_count SHALL increment by the number of requests deferred under REQ-021 in that cycle, and saturate at 16'hFFFF.
REQ-031 Requests left unscanned because all ports are used SHALL NOT count as conflicts.
REQ-032 A requester with req_valid=1 and req_ready=0 SHALL be retried in later cycles, and request fields are held stable by the requester until granted.
REQ-033 Fairness: every continuously valid, non-conflicting requester SHALL be granted within ceil(REQUESTERS/PORTS) cycles.

Reset
REQ-034 While rst=1, the outputs SHALL be held as follows:
- req_ready, mem_en, mem_addr and mem_d all 0;
- no grants issued.
REQ-035 On a clock edge with rst=1, the block SHALL set:
- rr_ptr=0;
- all rsp_valid=0, and the response pipeline cleared;
- conflict_count=0.
REQ-036 A read granted in the cycle before rst asserts SHALL NOT produce rsp_valid.

Verification
REQ-037 Parameters for all scenarios SHALL be PORTS=2, REQUESTERS=4, WIDTH=8, DEPTH=16.
REQ-038 Scenario, full load: all 4 requesters read distinct addresses from reset. Required response: grants {0,1} in cycle 0, then {2,3}, then {0,1}; rsp_valid one cycle after each grant.
REQ-039 Scenario, write conflict: r0 writes 8'hA5 to addr 3 and r1 reads addr 3 in the same cycle with rr_ptr=0. Required response:
- r0 granted, r1 deferred, conflict_count=1;
- r1 is granted the next cycle, then rsp_data=8'hA5.
REQ-040 Scenario, read sharing: r2 and r3 both read addr 7. Required response: both granted in one cycle on ports 0 and 1, and both receive the same data.
REQ-041 Scenario, pointer wrap: only r3 is valid and is granted. Required response: rr_ptr becomes 0; the next cycle with r0 and r3 both valid grants both, r0 on port 0.
REQ-042 Scenario, reset mid-operation: a read is granted at cycle t and rst=1 at the t edge. Required response: rsp_valid=0 at t+1, conflict_count=0, rr_ptr=0.
REQ-043 Scenario, saturation: force deferral repeatedly beyond 65535 conflicts. Required response: conflict_count holds 16'hFFFF.
